// File: rtl/bin2bcd_pkg.sv
// rtl/bin2bcd_pkg.sv - shared types and constants for the sequential binary-to-BCD converter
package bin2bcd_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      FINISH = 2'd2
   } state_e;

   localparam int          DIGITS       = 8;
   localparam logic [31:0] SAT_BCD      = 32'h9999_9999;
   localparam logic [31:0] MAX_BIN      = 32'd99_999_999;
   localparam logic [3:0]  BLANK_NIBBLE = 4'hF;

endpackage

// File: rtl/bin2bcd_seq_if.sv
// rtl/bin2bcd_seq_if.sv - request/result bundle between a client and bin2bcd_seq
interface bin2bcd_seq_if #(
   parameter int BIN_W = 27
);
   logic             START;
   logic [BIN_W-1:0] BIN;
   logic             BUSY;
   logic             DONE;
   logic [31:0]      BCD;
   logic             OVF;

   modport master (output START, BIN, input BUSY, DONE, BCD, OVF);
   modport slave  (input START, BIN, output BUSY, DONE, BCD, OVF);
endinterface

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - double-dabble digit correction: add 3 when the digit is 5 or more
module bcd_digit_adj (
   input  logic [3:0] digit_i,
   output logic [3:0] digit_o
);
   assign digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;
endmodule

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - shift-and-add-3 binary to 8-digit BCD converter, fixed BIN_W+1 latency
// Leading-zero blanking of the result is enabled by defining BIN2BCD_BLANK_EN.
module bin2bcd_seq
   import bin2bcd_pkg::*;
#(
   parameter int BIN_W = 27
) (
   input logic          CLK,
   input logic          RST,
   bin2bcd_seq_if.slave bus
);
   localparam int CNT_W = $clog2(BIN_W + 1);

   state_e           state_q, state_d;
   logic [BIN_W-1:0] shreg_q, shreg_d;
   logic [31:0]      scratch_q, scratch_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      bcd_q, bcd_d;
   logic             ovf_q, ovf_d;
   logic             ovf_pend_q, ovf_pend_d;

   logic [31:0]      adj;
   logic [31:0]      shifted;
   logic [31:0]      res_bcd;
   logic             ovf_now;

   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (
         .digit_i (scratch_q[4*g +: 4]),
         .digit_o (adj[4*g +: 4])
      );
   end

   assign shifted = {adj[30:0], shreg_q[BIN_W-1]};
   // A one leaving the top digit means the value has grown past eight digits.
   assign ovf_now = ovf_pend_q | adj[31];

`ifdef BIN2BCD_BLANK_EN
   logic lead;
`endif

   always_comb begin
      res_bcd = shifted;
`ifdef BIN2BCD_BLANK_EN
      lead = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         if (lead && (shifted[4*i +: 4] == 4'd0)) begin
            res_bcd[4*i +: 4] = BLANK_NIBBLE;
         end else begin
            lead = 1'b0;
         end
      end
`endif
   end

   always_comb begin
      state_d    = state_q;
      shreg_d    = shreg_q;
      scratch_d  = scratch_q;
      cnt_d      = cnt_q;
      bcd_d      = bcd_q;
      ovf_d      = ovf_q;
      ovf_pend_d = ovf_pend_q;
      case (state_q)
         IDLE: begin
            if (bus.START) begin
               shreg_d    = bus.BIN;
               scratch_d  = '0;
               cnt_d      = CNT_W'(BIN_W);
               ovf_pend_d = (32'(bus.BIN) > MAX_BIN);
               state_d    = SHIFT;
            end
         end
         SHIFT: begin
            scratch_d  = shifted;
            shreg_d    = {shreg_q[BIN_W-2:0], 1'b0};
            cnt_d      = cnt_q - CNT_W'(1);
            ovf_pend_d = ovf_now;
            // Result registers load only on the final shift so BCD never shows a partial value.
            if (cnt_q == CNT_W'(1)) begin
               bcd_d   = ovf_now ? SAT_BCD : res_bcd;
               ovf_d   = ovf_now;
               state_d = FINISH;
            end
         end
         FINISH: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= IDLE;
         shreg_q    <= '0;
         scratch_q  <= '0;
         cnt_q      <= '0;
         bcd_q      <= '0;
         ovf_q      <= 1'b0;
         ovf_pend_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         shreg_q    <= shreg_d;
         scratch_q  <= scratch_d;
         cnt_q      <= cnt_d;
         bcd_q      <= bcd_d;
         ovf_q      <= ovf_d;
         ovf_pend_q <= ovf_pend_d;
      end
   end

   assign bus.BUSY = (state_q != IDLE);
   assign bus.DONE = (state_q == FINISH) && !RST;
   assign bus.BCD  = bcd_q;
   assign bus.OVF  = ovf_q;

endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named CLK and RST.
REQ-002 Parameter BIN_W SHALL default to 27 and sets the binary input width; the supported range is 27..32.
REQ-003 Port CLK SHALL be an input, 1 bit wide, and is the system clock; all logic is rising-edge.
REQ-004 Port RST SHALL be an input, 1 bit wide, and is the synchronous, active-high reset.
REQ-005 Port START SHALL be an input, 1 bit wide, and is a conversion request, sampled only in IDLE.
REQ-006 Port BIN SHALL be an input, BIN_W bits wide, and is the unsigned binary value, sampled in the START cycle.
REQ-007 Port BUSY SHALL be an output, 1 bit wide, and is high while a conversion is in progress.
REQ-008 Port DONE SHALL be an output, 1 bit wide, and pulses high for one cycle when a new BCD result is valid.
REQ-009 Port BCD SHALL be an output, 32 bits wide, and carries 8 packed BCD digits with digit 0 at [3:0] and digit 7 at [31:28]; it feeds the 7-segment display stage directly.
REQ-010 Port OVF SHALL be an output, 1 bit wide, and is high when the last converted value exceeded 99,999,999.

Function
REQ-011 The FSM SHALL have three states: IDLE, SHIFT and FINISH.
REQ-012 In IDLE with START=1, the block SHALL latch BIN into a shift register, clear the 32-bit scratch BCD, load the bit counter with BIN_W, and go to SHIFT.
REQ-013 Each SHIFT cycle SHALL first add 3 to every scratch digit that is >=5, then shift {scratch, shift register} left by 1 and decrement the counter.
REQ-014 When the counter reaches 0, the FSM SHALL go to FINISH; FINISH SHALL update BCD and OVF, pulse DONE, and return to IDLE in the next cycle.
REQ-015 Latency SHALL be fixed: START sampled at cycle 0 gives DONE=1 and the new BCD at cycle BIN_W+1, independent of the data value.
REQ-016 BUSY SHALL be 1 from cycle 1 through cycle BIN_W+1, inclusive.
REQ-017 START asserted while not in IDLE SHALL be ignored, with no queueing.
REQ-018 START asserted in IDLE in the cycle immediately after DONE SHALL be accepted, giving back-to-back conversions every BIN_W+2 cycles.
REQ-019 BCD and OVF SHALL hold their previous values between updates; BCD SHALL never show a partial result.
REQ-020 If the latched BIN exceeds 99,999,999, the block SHALL still run the full latency, then set BCD=32'h99999999 (saturated) and OVF=1; otherwise OVF=0.
REQ-021 Every BCD nibble SHALL be in the range 0..9, except for blanked digits (see REQ-026).

Reset
REQ-022 RST=1 SHALL force state=IDLE, BUSY=0, DONE=0, OVF=0 and BCD=32'h00000000 at the next clock edge.
REQ-023 RST during SHIFT or FINISH SHALL abort the conversion: no DONE is produced, and BCD is cleared to 0.
REQ-024 RST and START asserted in the same cycle: reset SHALL win and START SHALL be ignored.

Configuration
REQ-025 Macro BIN2BCD_BLANK_EN SHALL select leading-zero blanking.
REQ-026 With BIN2BCD_BLANK_EN defined, in FINISH each leading zero digit, scanned from digit 7 down to digit 1, SHALL be replaced by 4'hF; digit 0 SHALL never be blanked. The display stage decodes 4'hF as all segments off.
REQ-027 Without BIN2BCD_BLANK_EN, all 8 digits SHALL be output as plain BCD.
REQ-028 The saturated value 32'h99999999 SHALL be unaffected by the macro setting.

Structure
REQ-029 Package bin2bcd_pkg SHALL hold the FSM state enum, DIGITS=8, SAT_BCD=32'h99999999, MAX_BIN=99_999_999 and BLANK_NIBBLE=4'hF.
REQ-030 A sub-module bcd_digit_adj (4-bit in, 4-bit out, add 3 if the input is >=5) SHALL be instantiated 8 times in the SHIFT datapath.
REQ-031 The leading-zero blanking logic SHALL be inline, under the macro guard.

Verification
REQ-032 The bench SHALL check: BIN=12345678, START pulse -> DONE at cycle 28 (BIN_W=27), BCD=32'h12345678, OVF=0.
REQ-033 The bench SHALL check: BIN=0 -> BCD=32'h00000000 without the macro, or 32'hFFFFFFF0 with BIN2BCD_BLANK_EN; OVF=0.
REQ-034 The bench SHALL check: BIN=99999999 -> BCD=32'h99999999, OVF=0; BIN=100000000 -> BCD=32'h99999999, OVF=1, with the same latency.
REQ-035 The bench SHALL check: BIN=405 with blanking enabled -> BCD=32'hFFFFF405; a second START at cycle 5 is ignored and exactly one DONE pulse occurs.
REQ-036 The bench SHALL check: START with BIN=777, then RST at cycle 10 -> no DONE, BCD=0, BUSY=0; a following START with BIN=42 -> BCD=32'h00000042 (or 32'hFFFFFF42 with blanking).
REQ-037 The bench SHALL check: 1000 random BIN values issued back-to-back, with START in the cycle after each DONE -> BCD matches the reference model and the period is exactly 29 cycles.
